// File: rtl/iq_classifier.sv
// iq_classifier: linear IQ discriminant d = coef_a*I + coef_b*Q - offset,
// three-stage pipeline (multiply, sum/subtract, compare) that emits a
// one-cycle strobe with a 2-bit class per accepted sample, plus a shot
// counter. Every sample carries its own offset/margin snapshot, so config
// writes never disturb samples already in flight.
module iq_classifier (
  input  logic        clk100,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] i_val,
  input  logic [15:0] q_val,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        data_out,
  output logic [1:0]  state,
  output logic [15:0] shot_count
);

  localparam int STAGES = 3;
  localparam int DW     = 34;   // |d| <= 2^32, needs 34 signed bits

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_GROUND  = 2'b01;
  localparam logic [1:0] ST_LINE    = 2'b10;
  localparam logic [1:0] ST_EXCITED = 2'b11;

  typedef enum logic [1:0] {
    SEL_COEF_A = 2'd0,
    SEL_COEF_B = 2'd1,
    SEL_OFFSET = 2'd2,
    SEL_MARGIN = 2'd3
  } cfg_sel_e;

  typedef struct packed {
    logic [15:0] coef_a;   // signed
    logic [15:0] coef_b;   // signed
    logic [31:0] offset;   // signed
    logic [31:0] margin;   // unsigned
  } cfg_t;

  // stage-1 payload: products plus the config the sample must finish with
  typedef struct packed {
    logic [31:0] prod_a;
    logic [31:0] prod_b;
    logic [31:0] offset;
    logic [31:0] margin;
  } s1_t;

  // stage-2 payload: full-width discriminant
  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   margin;
  } s2_t;

  cfg_t              cfg_q;
  s1_t               s1_q;
  s2_t               s2_q;
  logic [STAGES:1]   vld_pipe;

  logic signed [31:0]   prod_a_nxt;
  logic signed [31:0]   prod_b_nxt;
  logic signed [DW-1:0] d_nxt;
  logic [DW-1:0]        abs_d;
  logic [1:0]           class_nxt;

  // config registers; a write lands at this edge, so a sample accepted in
  // the same cycle still multiplies against the old coefficients
  always_ff @(posedge clk100) begin
    if (reset) begin
      cfg_q.coef_a <= 16'sd1;
      cfg_q.coef_b <= '0;
      cfg_q.offset <= '0;
      cfg_q.margin <= '0;
    end else if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        SEL_COEF_A: cfg_q.coef_a <= cfg_data[15:0];
        SEL_COEF_B: cfg_q.coef_b <= cfg_data[15:0];
        SEL_OFFSET: cfg_q.offset <= cfg_data;
        SEL_MARGIN: cfg_q.margin <= cfg_data;
        default:    ;
      endcase
    end
  end

  // valid shift register; reset drops everything in flight
  always_ff @(posedge clk100) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], sample_valid};
  end

  // signed 16x16 products, both operands sign-extended to 32 bits
  always_comb begin
    prod_a_nxt = 32'($signed(cfg_q.coef_a)) * 32'($signed(i_val));
    prod_b_nxt = 32'($signed(cfg_q.coef_b)) * 32'($signed(q_val));
  end

  // stage 1: multiply, snapshot offset/margin alongside the sample
  always_ff @(posedge clk100) begin
    s1_q.prod_a <= prod_a_nxt;
    s1_q.prod_b <= prod_b_nxt;
    s1_q.offset <= cfg_q.offset;
    s1_q.margin <= cfg_q.margin;
  end

  // 34-bit sum/subtract cannot overflow: range is roughly [-2^32, 2^32]
  always_comb begin
    d_nxt = DW'($signed(s1_q.prod_a)) + DW'($signed(s1_q.prod_b))
          - DW'($signed(s1_q.offset));
  end

  // stage 2: discriminant
  always_ff @(posedge clk100) begin
    s2_q.d      <= d_nxt;
    s2_q.margin <= s1_q.margin;
  end

  // compare: inside the margin band is ambiguous, otherwise sign decides;
  // d == 0 outside the band counts as ground
  always_comb begin
    abs_d     = s2_q.d[DW-1] ? DW'(-s2_q.d) : s2_q.d;
    class_nxt = ST_GROUND;
    if (abs_d < {2'b00, s2_q.margin})
      class_nxt = ST_LINE;
    else if (!s2_q.d[DW-1] && (s2_q.d != '0))
      class_nxt = ST_EXCITED;
  end

  // stage 3: strobe, held class and shot counter (wraps naturally)
  always_ff @(posedge clk100) begin
    if (reset) begin
      state      <= ST_NONE;
      shot_count <= '0;
    end else if (vld_pipe[STAGES-1]) begin
      state      <= class_nxt;
      shot_count <= shot_count + 16'd1;
    end
  end

  assign data_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_iq_classifier.sv
// Directed bench for iq_classifier: hand-computed discriminants and classes,
// latency/strobe shape, config timing, reset discard and counter wrap.
module tb_iq_classifier;

  logic        clk100 = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] i_val;
  logic [15:0] q_val;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        data_out;
  logic [1:0]  state;
  logic [15:0] shot_count;

  logic [15:0] exp_shots;
  int          errors = 0;
  int          checks = 0;

  always #5 clk100 = ~clk100;

  iq_classifier dut (
    .clk100       (clk100),
    .reset        (reset),
    .sample_valid (sample_valid),
    .i_val        (i_val),
    .q_val        (q_val),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .data_out     (data_out),
    .state        (state),
    .shot_count   (shot_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic drive(input int i, input int q);
    i_val = 16'(i);
    q_val = 16'(q);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  // single isolated sample: strobe must appear exactly 3 cycles later
  task automatic one(input int i, input int q, input logic [1:0] exp_st, input string tag);
    sample_valid = 1'b1;
    drive(i, q);
    tick();
    sample_valid = 1'b0;
    check({tag, "/n+1"}, 64'(data_out), 64'd0);
    tick();
    check({tag, "/n+2"}, 64'(data_out), 64'd0);
    tick();
    exp_shots = exp_shots + 16'd1;
    check({tag, "/strobe"}, 64'(data_out), 64'd1);
    check({tag, "/state"},  64'(state), 64'(exp_st));
    check({tag, "/shots"},  64'(shot_count), 64'(exp_shots));
    tick();
    check({tag, "/n+4"},  64'(data_out), 64'd0);
    check({tag, "/hold"}, 64'(state), 64'(exp_st));
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; cfg_we = 1'b0;
    cfg_sel = 2'd0; cfg_data = '0; drive(0, 0);
    exp_shots = '0;
    tick(); tick();
    check("rst/dout",  64'(data_out), 64'd0);
    check("rst/state", 64'(state), 64'd0);
    check("rst/shots", 64'(shot_count), 64'd0);
    reset = 1'b0;

    // defaults: coef_a=1, coef_b=0, offset=0, margin=0
    one(100, 0, 2'b11, "i100");
    one(0, 1234, 2'b01, "d0_m0");

    // margin band, back-to-back samples
    cfg(2'd3, 32'd10);
    sample_valid = 1'b1;
    drive(5, 0);   tick();
    drive(-5, 0);  check("b2b/n+1", 64'(data_out), 64'd0); tick();
    drive(-20, 0); tick();
    sample_valid = 1'b0;
    check("b2b/s0", 64'(data_out), 64'd1);
    check("b2b/c0", 64'(state), 64'(2'b10));
    tick();
    check("b2b/s1", 64'(data_out), 64'd1);
    check("b2b/c1", 64'(state), 64'(2'b10));
    tick();
    check("b2b/s2", 64'(data_out), 64'd1);
    check("b2b/c2", 64'(state), 64'(2'b01));
    exp_shots = exp_shots + 16'd3;
    check("b2b/shots", 64'(shot_count), 64'(exp_shots));
    tick();
    check("b2b/end", 64'(data_out), 64'd0);
    one(10, 0, 2'b11, "abs_eq_margin");
    one(-9, 0, 2'b10, "abs_lt_margin");

    // coefficients and offset; upper cfg bits ignored for coef_b
    cfg(2'd3, 32'd0);
    cfg(2'd0, 32'h0000_0002);
    cfg(2'd1, 32'hABCD_FFFD);
    cfg(2'd2, 32'd4);
    one(10, 5, 2'b11, "d_p1");
    one(10, 6, 2'b01, "d_m2");

    // write coef_a=5 with a sample in the same cycle: sample sees coef_a=2
    cfg(2'd2, 32'd0);
    cfg(2'd3, 32'd3);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'd5;
    sample_valid = 1'b1; drive(1, 0);
    tick();
    cfg_we = 1'b0; sample_valid = 1'b0;
    tick(); tick();
    exp_shots = exp_shots + 16'd1;
    check("same_cyc/strobe", 64'(data_out), 64'd1);
    check("same_cyc/state",  64'(state), 64'(2'b10));
    tick();
    one(1, 0, 2'b11, "coef_new");

    // margin changes while the sample is in flight: old margin applies
    sample_valid = 1'b1; drive(1, 0);
    tick();
    sample_valid = 1'b0;
    cfg(2'd3, 32'd100);
    tick();
    exp_shots = exp_shots + 16'd1;
    check("inflight/strobe", 64'(data_out), 64'd1);
    check("inflight/state",  64'(state), 64'(2'b11));
    tick();
    one(1, 0, 2'b10, "margin_new");

    // extremes: d = 2^32 above a max margin; large negative d
    cfg(2'd0, 32'h0000_8000);
    cfg(2'd1, 32'hFFFF_8000);
    cfg(2'd2, 32'h8000_0000);
    cfg(2'd3, 32'hFFFF_FFFF);
    one(-32768, -32768, 2'b11, "d_2p32");
    cfg(2'd2, 32'h7FFF_FFFF);
    cfg(2'd3, 32'd0);
    one(32767, 32767, 2'b01, "d_neg_big");

    // reset beats cfg_we; first cycle after reset accepts a sample
    reset = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 32'd100;
    tick();
    reset = 1'b0; cfg_we = 1'b0;
    exp_shots = '0;
    check("rstp/state", 64'(state), 64'd0);
    check("rstp/shots", 64'(shot_count), 64'd0);
    one(5, 0, 2'b11, "rstp/first");

    // one-cycle reset discards an in-flight sample
    sample_valid = 1'b1; drive(100, 0);
    tick();
    sample_valid = 1'b0; reset = 1'b1;
    check("discard/n+1", 64'(data_out), 64'd0);
    tick();
    reset = 1'b0;
    exp_shots = '0;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("discard/n+%0d", k), 64'(data_out), 64'd0);
      tick();
    end
    check("discard/state", 64'(state), 64'd0);
    check("discard/shots", 64'(shot_count), 64'd0);

    // counter wrap: 65535 streamed samples, then one more
    sample_valid = 1'b1; drive(1, 0);
    for (int k = 0; k < 65535; k++) begin
      tick();
      if (k == 10) check("stream/strobe", 64'(data_out), 64'd1);
    end
    sample_valid = 1'b0;
    tick(); tick(); tick();
    exp_shots = 16'hFFFF;
    check("wrap/ffff", 64'(shot_count), 64'hFFFF);
    one(1, 0, 2'b11, "wrap/zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
